dc_mem_ctrl: RTL and testbench

- Memory-side sequencer that services the data cache's miss, evict and uncached IO requests, plus instruction cache line fills, over one shared 32-bit memory bus.
- Performs dirty-line writeback (4 beats), then line fill (4 beats). Assembles the 128-bit fill line and returns it with a one-cycle ack.
- Arbitrates dcache vs icache line traffic round-robin. IO has the highest priority.

---
 rtl/dc_mem_ctrl_pkg.sv | 45 ++++
 rtl/dc_mem_ctrl_mem_beat_seq.sv | 75 +++++++
 rtl/dc_mem_ctrl.sv | 215 +++++++++++++++++++++
 tb/tb_dc_mem_ctrl.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dc_mem_ctrl_pkg.sv
// Shared types and constants for the data-cache memory sequencer.
// Covers the FSM state encoding, requester IDs and line/beat slicing helpers.
package dc_mem_ctrl_pkg;

    localparam int BUS_W  = 32;
    localparam int LINE_W = 128;
    localparam int BEATS  = LINE_W / BUS_W;
    localparam int CNT_W  = 2;

    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);
    localparam logic [CNT_W-1:0] ONE_BEAT  = 2'd0;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_IO_BEAT = 3'd1,
        ST_IO_ACK  = 3'd2,
        ST_DC_WB   = 3'd3,
        ST_DC_FILL = 3'd4,
        ST_DC_ACK  = 3'd5,
        ST_IC_FILL = 3'd6,
        ST_IC_ACK  = 3'd7
    } state_t;

    typedef enum logic [1:0] {
        REQ_IO = 2'd0,
        REQ_DC = 2'd1,
        REQ_IC = 2'd2
    } req_id_t;

    // Beat k occupies bits [32k+31:32k] of a line.
    function automatic logic [BUS_W-1:0] line_beat(input logic [LINE_W-1:0] line,
                                                   input logic [CNT_W-1:0]  idx);
        return line[{idx, 5'd0} +: BUS_W];
    endfunction

    function automatic logic [LINE_W-1:0] line_insert(input logic [LINE_W-1:0] line,
                                                      input logic [CNT_W-1:0]  idx,
                                                      input logic [BUS_W-1:0]  word);
        logic [LINE_W-1:0] res;
        res = line;
        res[{idx, 5'd0} +: BUS_W] = word;
        return res;
    endfunction

endpackage

// File: rtl/dc_mem_ctrl_mem_beat_seq.sv
// Bus beat sequencer: runs one phase of 1..BEATS beats from a base address,
// holding bus_req across back-to-back beats and flagging the last bus_ack.
module mem_beat_seq
    import dc_mem_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              start_rw,
    input  logic [CNT_W-1:0]  start_last,
    input  logic [31:0]       start_base,
    input  logic [LINE_W-1:0] start_line,
    input  logic              bus_ack,
    output logic              bus_req,
    output logic              bus_rw,
    output logic [31:0]       bus_addr,
    output logic [BUS_W-1:0]  bus_wdata,
    output logic [CNT_W-1:0]  beat_idx,
    output logic              beat_done,
    output logic              last_done,
    output logic              busy
);

    logic              req_r;
    logic              rw_r;
    logic [31:0]       addr_r;
    logic [BUS_W-1:0]  wdata_r;
    logic [CNT_W-1:0]  cnt_r;
    logic [CNT_W-1:0]  last_r;
    logic [LINE_W-1:0] line_r;
    logic [CNT_W-1:0]  cnt_nxt_s;

    // An ack with no outstanding request is not a beat.
    assign beat_done = req_r & bus_ack;
    assign last_done = beat_done & (cnt_r == last_r);
    assign cnt_nxt_s = cnt_r + 2'd1;

    assign bus_req   = req_r;
    assign bus_rw    = rw_r;
    assign bus_addr  = addr_r;
    assign bus_wdata = wdata_r;
    assign beat_idx  = cnt_r;
    assign busy      = req_r;

    // Phase registers: load on start, step address/data on each acked beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            req_r   <= 1'b0;
            rw_r    <= 1'b0;
            addr_r  <= 32'd0;
            wdata_r <= {BUS_W{1'b0}};
            cnt_r   <= {CNT_W{1'b0}};
            last_r  <= {CNT_W{1'b0}};
            line_r  <= {LINE_W{1'b0}};
        end else if (start) begin
            req_r   <= 1'b1;
            rw_r    <= start_rw;
            addr_r  <= start_base;
            wdata_r <= line_beat(start_line, 2'd0);
            cnt_r   <= {CNT_W{1'b0}};
            last_r  <= start_last;
            line_r  <= start_line;
        end else if (beat_done) begin
            if (last_done) begin
                req_r <= 1'b0;
                cnt_r <= {CNT_W{1'b0}};
            end else begin
                cnt_r   <= cnt_nxt_s;
                addr_r  <= addr_r + 32'd4;
                wdata_r <= line_beat(line_r, cnt_nxt_s);
            end
        end
    end

endmodule

// File: rtl/dc_mem_ctrl.sv
// Memory-side sequencer for dcache miss/evict, uncached IO and icache fills
// over one shared 32-bit bus. IO wins outright; dcache/icache alternate.
module dc_mem_ctrl
    import dc_mem_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              dc_miss,
    input  logic [31:0]       dc_miss_addr,
    input  logic              dc_evict,
    input  logic [31:0]       dc_evict_addr,
    input  logic [LINE_W-1:0] dc_evict_data,
    output logic [LINE_W-1:0] dc_data_fill,
    output logic              dc_miss_ack,
    input  logic              io_access,
    input  logic              io_rw,
    input  logic [31:0]       io_addr,
    input  logic [31:0]       io_wr_data,
    output logic [31:0]       io_rd_data,
    output logic              io_ack,
    input  logic              ic_miss,
    input  logic [31:0]       ic_miss_addr,
    output logic [LINE_W-1:0] ic_data_fill,
    output logic              ic_miss_ack,
    output logic              bus_req,
    output logic              bus_rw,
    output logic [31:0]       bus_addr,
    output logic [BUS_W-1:0]  bus_wdata,
    input  logic [BUS_W-1:0]  bus_rdata,
    input  logic              bus_ack
);

    state_t            state_r, state_nxt_s;
    req_id_t           rr_last_r, rr_nxt_s;
    logic [31:0]       dc_fill_addr_r;
    logic [LINE_W-1:0] fill_buf_r;
    logic [LINE_W-1:0] fill_nxt_s;
    logic [LINE_W-1:0] dc_data_fill_r;
    logic [LINE_W-1:0] ic_data_fill_r;
    logic [31:0]       io_rd_data_r;
    logic              dc_miss_ack_r;
    logic              ic_miss_ack_r;
    logic              io_ack_r;

    logic              start_s;
    logic              start_rw_s;
    logic [CNT_W-1:0]  start_last_s;
    logic [31:0]       start_base_s;
    logic [LINE_W-1:0] start_line_s;
    logic              dc_grant_s;
    logic              fill_capture_s;
    logic              dc_fill_end_s;
    logic              ic_fill_end_s;
    logic              io_end_s;

    logic              seq_rw_s;
    logic [CNT_W-1:0]  seq_beat_idx_s;
    logic              seq_beat_done_s;
    logic              seq_last_done_s;
    logic              seq_busy_s;

    mem_beat_seq u_beat_seq (
        .clk        (clk),
        .rst        (rst),
        .start      (start_s),
        .start_rw   (start_rw_s),
        .start_last (start_last_s),
        .start_base (start_base_s),
        .start_line (start_line_s),
        .bus_ack    (bus_ack),
        .bus_req    (bus_req),
        .bus_rw     (seq_rw_s),
        .bus_addr   (bus_addr),
        .bus_wdata  (bus_wdata),
        .beat_idx   (seq_beat_idx_s),
        .beat_done  (seq_beat_done_s),
        .last_done  (seq_last_done_s),
        .busy       (seq_busy_s)
    );

    assign bus_rw       = seq_rw_s;
    assign dc_data_fill = dc_data_fill_r;
    assign ic_data_fill = ic_data_fill_r;
    assign io_rd_data   = io_rd_data_r;
    assign dc_miss_ack  = dc_miss_ack_r;
    assign ic_miss_ack  = ic_miss_ack_r;
    assign io_ack       = io_ack_r;

    assign fill_nxt_s     = line_insert(fill_buf_r, seq_beat_idx_s, bus_rdata);
    assign fill_capture_s = seq_beat_done_s & ~seq_rw_s &
                            ((state_r == ST_DC_FILL) | (state_r == ST_IC_FILL));
    assign dc_fill_end_s  = (state_r == ST_DC_FILL) & seq_last_done_s;
    assign ic_fill_end_s  = (state_r == ST_IC_FILL) & seq_last_done_s;
    assign io_end_s       = (state_r == ST_IO_BEAT) & seq_last_done_s;

    // Arbitration, phase launch and next-state decode.
    always_comb begin
        state_nxt_s  = state_r;
        rr_nxt_s     = rr_last_r;
        start_s      = 1'b0;
        start_rw_s   = 1'b0;
        start_last_s = LAST_BEAT;
        start_base_s = 32'd0;
        start_line_s = {LINE_W{1'b0}};
        dc_grant_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (io_access) begin
                    state_nxt_s  = ST_IO_BEAT;
                    start_s      = 1'b1;
                    start_rw_s   = io_rw;
                    start_last_s = ONE_BEAT;
                    start_base_s = io_addr;
                    start_line_s = {{(LINE_W-BUS_W){1'b0}}, io_wr_data};
                end else if (dc_miss && (!ic_miss || rr_last_r == REQ_IC)) begin
                    dc_grant_s = 1'b1;
                    rr_nxt_s   = REQ_DC;
                    start_s    = 1'b1;
                    if (dc_evict) begin
                        state_nxt_s  = ST_DC_WB;
                        start_rw_s   = 1'b1;
                        start_base_s = dc_evict_addr;
                        start_line_s = dc_evict_data;
                    end else begin
                        state_nxt_s  = ST_DC_FILL;
                        start_base_s = dc_miss_addr;
                    end
                end else if (ic_miss) begin
                    rr_nxt_s     = REQ_IC;
                    state_nxt_s  = ST_IC_FILL;
                    start_s      = 1'b1;
                    start_base_s = ic_miss_addr;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_IO_BEAT: begin
                if (seq_last_done_s) begin
                    state_nxt_s = ST_IO_ACK;
                end else begin
                    state_nxt_s = ST_IO_BEAT;
                end
            end
            ST_DC_WB: begin
                if (seq_last_done_s) begin
                    state_nxt_s = ST_DC_FILL;
                end else begin
                    state_nxt_s = ST_DC_WB;
                end
            end
            ST_DC_FILL: begin
                // After a writeback bus_req has dropped; relaunch for the fill.
                if (!seq_busy_s) begin
                    start_s      = 1'b1;
                    start_base_s = dc_fill_addr_r;
                end else if (seq_last_done_s) begin
                    state_nxt_s = ST_DC_ACK;
                end else begin
                    state_nxt_s = ST_DC_FILL;
                end
            end
            ST_IC_FILL: begin
                if (seq_last_done_s) begin
                    state_nxt_s = ST_IC_ACK;
                end else begin
                    state_nxt_s = ST_IC_FILL;
                end
            end
            ST_IO_ACK, ST_DC_ACK, ST_IC_ACK: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State, arbitration history, fill assembly and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r        <= ST_IDLE;
            rr_last_r      <= REQ_IC;
            dc_fill_addr_r <= 32'd0;
            fill_buf_r     <= {LINE_W{1'b0}};
            dc_data_fill_r <= {LINE_W{1'b0}};
            ic_data_fill_r <= {LINE_W{1'b0}};
            io_rd_data_r   <= 32'd0;
            dc_miss_ack_r  <= 1'b0;
            ic_miss_ack_r  <= 1'b0;
            io_ack_r       <= 1'b0;
        end else begin
            state_r       <= state_nxt_s;
            rr_last_r     <= rr_nxt_s;
            dc_miss_ack_r <= dc_fill_end_s;
            ic_miss_ack_r <= ic_fill_end_s;
            io_ack_r      <= io_end_s;
            if (dc_grant_s) begin
                dc_fill_addr_r <= dc_miss_addr;
            end
            if (fill_capture_s) begin
                fill_buf_r <= fill_nxt_s;
            end
            if (dc_fill_end_s) begin
                dc_data_fill_r <= fill_nxt_s;
            end
            if (ic_fill_end_s) begin
                ic_data_fill_r <= fill_nxt_s;
            end
            if (io_end_s && !seq_rw_s) begin
                io_rd_data_r <= bus_rdata;
            end
        end
    end

endmodule

// File: tb/tb_dc_mem_ctrl.sv
// Directed self-checking bench for dc_mem_ctrl with a small memory model that
// acks beats after a programmable number of request cycles.
module tb_dc_mem_ctrl;
    import dc_mem_ctrl_pkg::*;

    logic              clk = 1'b0;
    logic              rst;
    logic              dc_miss, dc_evict, io_access, io_rw, ic_miss;
    logic [31:0]       dc_miss_addr, dc_evict_addr, io_addr, io_wr_data, ic_miss_addr;
    logic [LINE_W-1:0] dc_evict_data, dc_data_fill, ic_data_fill;
    logic              dc_miss_ack, io_ack, ic_miss_ack;
    logic [31:0]       io_rd_data, bus_addr;
    logic              bus_req, bus_rw, bus_ack;
    logic [BUS_W-1:0]  bus_wdata, bus_rdata;

    always #5 clk = ~clk;

    dc_mem_ctrl dut (
        .clk(clk), .rst(rst),
        .dc_miss(dc_miss), .dc_miss_addr(dc_miss_addr), .dc_evict(dc_evict),
        .dc_evict_addr(dc_evict_addr), .dc_evict_data(dc_evict_data),
        .dc_data_fill(dc_data_fill), .dc_miss_ack(dc_miss_ack),
        .io_access(io_access), .io_rw(io_rw), .io_addr(io_addr), .io_wr_data(io_wr_data),
        .io_rd_data(io_rd_data), .io_ack(io_ack),
        .ic_miss(ic_miss), .ic_miss_addr(ic_miss_addr), .ic_data_fill(ic_data_fill),
        .ic_miss_ack(ic_miss_ack),
        .bus_req(bus_req), .bus_rw(bus_rw), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_rdata(bus_rdata), .bus_ack(bus_ack)
    );

    int n_checks = 0;
    int n_errors = 0;

    int          wait_n = 1;
    logic [31:0] rd_xor = 32'd0;
    int          wcnt = 0;
    logic [31:0] log_addr[$];
    logic        log_rw[$];
    logic [31:0] log_wdata[$];
    int          order_q[$];
    int          dc_acks = 0, ic_acks = 0, io_acks = 0;
    int          beats_at_dc_ack = 0;
    int          unstable = 0;
    logic [31:0] io_rd_seen = 32'd0;
    logic [31:0] prev_addr = 32'd0;
    logic        prev_rw = 1'b0;
    logic        prev_wait = 1'b0;
    int          cyc;
    int          d0;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [3:0] nib;
        nib = {2'b00, a[3:2]} + 4'd1;
        return {8{nib}} ^ rd_xor;
    endfunction

    // Memory model and ack monitor, all on the falling edge.
    initial begin
        bus_ack   = 1'b0;
        bus_rdata = 32'd0;
        forever begin
            @(negedge clk);
            if (dc_miss_ack) begin
                dc_acks++;
                order_q.push_back(1);
                beats_at_dc_ack = log_addr.size();
            end
            if (ic_miss_ack) begin
                ic_acks++;
                order_q.push_back(2);
            end
            if (io_ack) begin
                io_acks++;
                order_q.push_back(0);
                io_rd_seen = io_rd_data;
            end
            if (prev_wait && bus_req && (bus_addr !== prev_addr || bus_rw !== prev_rw))
                unstable++;
            if (rst) begin
                bus_ack = 1'b0;
                wcnt = 0;
            end else if (bus_ack) begin
                bus_ack = 1'b0;
                wcnt = bus_req ? 1 : 0;
            end else if (bus_req) begin
                if (wcnt >= wait_n) begin
                    bus_ack   = 1'b1;
                    bus_rdata = mem_word(bus_addr);
                    log_addr.push_back(bus_addr);
                    log_rw.push_back(bus_rw);
                    log_wdata.push_back(bus_wdata);
                    wcnt = 0;
                end else begin
                    wcnt++;
                end
            end else begin
                wcnt = 0;
            end
            prev_wait = bus_req && !bus_ack;
            prev_addr = bus_addr;
            prev_rw   = bus_rw;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic wait_count(input string tag, input int which, input int target,
                              input int budget, output int cycles);
        int seen;
        seen = 0;
        cycles = 0;
        for (int i = 0; i < budget; i++) begin
            tick(1);
            cycles = i + 1;
            case (which)
                0:       seen = io_acks;
                1:       seen = dc_acks;
                default: seen = ic_acks;
            endcase
            if (seen >= target) break;
        end
        check_eq(tag, seen, target);
    endtask

    task automatic clear_log();
        log_addr.delete();
        log_rw.delete();
        log_wdata.delete();
    endtask

    task automatic check_reads(input string tag, input int first, input logic [31:0] base);
        for (int k = 0; k < 4; k++) begin
            if (first + k < log_addr.size()) begin
                check_eq($sformatf("%s_addr%0d", tag, k), log_addr[first+k], base + 32'(4*k));
                check_eq($sformatf("%s_rw%0d", tag, k), log_rw[first+k], 1'b0);
            end
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: run did not complete, checks=%0d", n_checks);
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        dc_miss = 1'b0; dc_evict = 1'b0; io_access = 1'b0; io_rw = 1'b0; ic_miss = 1'b0;
        dc_miss_addr = 32'd0; dc_evict_addr = 32'd0; io_addr = 32'd0; io_wr_data = 32'd0;
        ic_miss_addr = 32'd0; dc_evict_data = {LINE_W{1'b0}};
        tick(3);
        check_eq("rst_bus_req", bus_req, 1'b0);
        check_eq("rst_bus_addr", bus_addr, 32'd0);
        check_eq("rst_acks", {dc_miss_ack, ic_miss_ack, io_ack}, 3'b000);
        check_eq("rst_dc_fill", dc_data_fill, 128'd0);
        check_eq("rst_ic_fill", ic_data_fill, 128'd0);
        check_eq("rst_io_rd", io_rd_data, 32'd0);
        rst = 1'b0;
        tick(2);

        // Clean dcache miss, zero-wait memory.
        clear_log();
        dc_miss_addr = 32'h0000_1230;
        dc_miss = 1'b1;
        wait_count("clean_ack", 1, 1, 60, cyc);
        dc_miss = 1'b0;
        check_eq("clean_latency", cyc, 10);
        tick(5);
        check_eq("clean_ack_once", dc_acks, 1);
        check_eq("clean_beats", log_addr.size(), 4);
        check_reads("clean", 0, 32'h0000_1230);
        check_eq("clean_fill", dc_data_fill, 128'h44444444_33333333_22222222_11111111);

        // Dirty miss: writeback then fill.
        clear_log();
        rd_xor = 32'hFFFF_0000;
        dc_evict = 1'b1;
        dc_evict_addr = 32'h0000_0400;
        dc_evict_data = 128'hAAAA0003_AAAA0002_AAAA0001_AAAA0000;
        dc_miss_addr = 32'h0000_2000;
        dc_miss = 1'b1;
        wait_count("dirty_ack", 1, 2, 100, cyc);
        dc_miss = 1'b0;
        dc_evict = 1'b0;
        tick(3);
        check_eq("dirty_beats", log_addr.size(), 8);
        check_eq("dirty_ack_after_fill", beats_at_dc_ack, 8);
        for (int k = 0; k < 4; k++) begin
            if (k < log_addr.size()) begin
                check_eq($sformatf("wb_addr%0d", k), log_addr[k], 32'h0000_0400 + 32'(4*k));
                check_eq($sformatf("wb_rw%0d", k), log_rw[k], 1'b1);
                check_eq($sformatf("wb_data%0d", k), log_wdata[k], 32'hAAAA_0000 + 32'(k));
            end
        end
        check_reads("dirty_fill", 4, 32'h0000_2000);
        check_eq("dirty_fill", dc_data_fill, 128'hBBBB4444_CCCC3333_DDDD2222_EEEE1111);

        // IO priority over simultaneous line requests, then DC then IC.
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(1);
        clear_log();
        order_q.delete();
        rd_xor = 32'h1234_5678;
        io_rw = 1'b0;
        io_addr = 32'hFFFF_0010;
        dc_miss_addr = 32'h0000_3000;
        ic_miss_addr = 32'h0000_5000;
        io_access = 1'b1;
        dc_miss = 1'b1;
        ic_miss = 1'b1;
        wait_count("prio_io", 0, 1, 40, cyc);
        io_access = 1'b0;
        wait_count("prio_dc", 1, 3, 60, cyc);
        dc_miss = 1'b0;
        wait_count("prio_ic", 2, 1, 60, cyc);
        ic_miss = 1'b0;
        tick(2);
        check_eq("prio_order_len", order_q.size(), 3);
        if (order_q.size() == 3) begin
            check_eq("prio_first_io", order_q[0], 0);
            check_eq("prio_second_dc", order_q[1], 1);
            check_eq("prio_third_ic", order_q[2], 2);
        end
        check_eq("io_rd_at_ack", io_rd_seen, 32'h0325_4769);
        check_eq("io_rd_held", io_rd_data, 32'h0325_4769);
        if (log_addr.size() == 9) begin
            check_eq("io_addr", log_addr[0], 32'hFFFF_0010);
            check_eq("io_rw", log_rw[0], 1'b0);
        end
        check_reads("prio_dc", 1, 32'h0000_3000);
        check_reads("prio_ic", 5, 32'h0000_5000);
        check_eq("prio_ic_fill", ic_data_fill, 128'h5670123C_2107654B_3016745A_03254769);
        check_eq("prio_dc_fill", dc_data_fill, 128'h5670123C_2107654B_3016745A_03254769);

        // IO write leaves io_rd_data untouched.
        clear_log();
        io_rw = 1'b1;
        io_addr = 32'hFFFF_0020;
        io_wr_data = 32'hDEAD_BEEF;
        io_access = 1'b1;
        wait_count("iow_ack", 0, 2, 40, cyc);
        io_access = 1'b0;
        tick(2);
        check_eq("iow_beats", log_addr.size(), 1);
        if (log_addr.size() == 1) begin
            check_eq("iow_addr", log_addr[0], 32'hFFFF_0020);
            check_eq("iow_rw", log_rw[0], 1'b1);
            check_eq("iow_data", log_wdata[0], 32'hDEAD_BEEF);
        end
        check_eq("iow_rd_unchanged", io_rd_data, 32'h0325_4769);

        // Round-robin with both line requests held.
        order_q.delete();
        rd_xor = 32'd0;
        dc_miss_addr = 32'h0000_6000;
        ic_miss_addr = 32'h0000_7000;
        dc_miss = 1'b1;
        ic_miss = 1'b1;
        for (int i = 0; i < 300; i++) begin
            tick(1);
            if (order_q.size() >= 4) break;
        end
        dc_miss = 1'b0;
        ic_miss = 1'b0;
        tick(3);
        check_eq("rr_len", order_q.size(), 4);
        if (order_q.size() == 4) begin
            check_eq("rr_order", {order_q[0][1:0], order_q[1][1:0], order_q[2][1:0], order_q[3][1:0]},
                     8'b01_10_01_10);
        end

        // Wait states: 3 extra cycles per beat.
        wait_n = 4;
        clear_log();
        unstable = 0;
        d0 = dc_acks;
        dc_miss_addr = 32'h0000_0800;
        dc_miss = 1'b1;
        wait_count("ws_ack", 1, d0 + 1, 200, cyc);
        dc_miss = 1'b0;
        tick(3);
        wait_n = 1;
        check_eq("ws_latency", cyc, 22);
        check_eq("ws_stable", unstable, 0);
        check_eq("ws_beats", log_addr.size(), 4);
        check_reads("ws", 0, 32'h0000_0800);
        check_eq("ws_fill", dc_data_fill, 128'h44444444_33333333_22222222_11111111);

        // Reset during fill beat 2, then a clean retry.
        clear_log();
        d0 = dc_acks;
        dc_miss_addr = 32'h0000_1230;
        dc_miss = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tick(1);
            if (log_addr.size() >= 2) break;
        end
        check_eq("rstmid_at_beat2", log_addr.size(), 2);
        rst = 1'b1;
        dc_miss = 1'b0;
        tick(1);
        check_eq("rstmid_bus_req", bus_req, 1'b0);
        check_eq("rstmid_fill_cleared", dc_data_fill, 128'd0);
        rst = 1'b0;
        tick(15);
        check_eq("rstmid_no_ack", dc_acks, d0);
        clear_log();
        dc_miss = 1'b1;
        wait_count("rstmid_redo", 1, d0 + 1, 60, cyc);
        dc_miss = 1'b0;
        tick(2);
        check_eq("rstmid_redo_beats", log_addr.size(), 4);
        check_eq("rstmid_redo_fill", dc_data_fill, 128'h44444444_33333333_22222222_11111111);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
